// File: rtl/layer2_maxpool_store.sv
// rtl/layer2_maxpool_store.sv - 2x2 stride-2 per-channel max pooling of the layer-2 conv stream
// Pools a raster-order IN_WIDTH x IN_WIDTH map and writes each pooled pixel to the result memory.
module layer2_maxpool_store #(
  parameter int IN_WIDTH = 28,
  parameter int CH       = 8,
  parameter int DW       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [CH*DW-1:0] in_data,
  output logic             in_ready,
  output logic             save_enable,
  output logic [15:0]      save_row_addr,
  output logic [15:0]      save_col_addr,
  output logic [CH*DW-1:0] store_data_out,
  output logic             busy,
  output logic             layer2_done
);

  localparam int CW = $clog2(IN_WIDTH);
  localparam int OW = IN_WIDTH / 2;
  localparam int VW = CH * DW;
  localparam logic [CW-1:0] LAST = CW'(IN_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   row_q;
  logic [CW-1:0]   col_q;
  logic [VW-1:0]   hold_q;
  logic [VW-1:0]   line_buf_q [OW];
  logic [VW-1:0]   result_q;
  logic            save_en_q;
  logic [15:0]     row_addr_q;
  logic [15:0]     col_addr_q;

  logic [CW-2:0]   lb_idx_d;
  logic [VW-1:0]   pair_max_d;
  logic [VW-1:0]   win_max_d;

  function automatic logic [VW-1:0] vmax(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0] r;
    r = '0;
    for (int k = 0; k < CH; k++) begin
      r[k*DW +: DW] = ($signed(a[k*DW +: DW]) > $signed(b[k*DW +: DW])) ? a[k*DW +: DW]
                                                                        : b[k*DW +: DW];
    end
    return r;
  endfunction

  // Top pair of a window is folded into the line buffer; the bottom pair meets it there.
  assign lb_idx_d   = col_q[CW-1:1];
  assign pair_max_d = vmax(hold_q, in_data);
  assign win_max_d  = vmax(pair_max_d, line_buf_q[lb_idx_d]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      hold_q     <= '0;
      result_q   <= '0;
      save_en_q  <= 1'b0;
      row_addr_q <= '0;
      col_addr_q <= '0;
      for (int i = 0; i < OW; i++) line_buf_q[i] <= '0;
    end else begin
      save_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            row_q   <= '0;
            col_q   <= '0;
          end
        end
        RUN: begin
          if (in_valid) begin
            if (!col_q[0]) begin
              hold_q <= in_data;
            end else if (!row_q[0]) begin
              line_buf_q[lb_idx_d] <= pair_max_d;
            end else begin
              result_q   <= win_max_d;
              save_en_q  <= 1'b1;
              row_addr_q <= {{(17 - CW){1'b0}}, row_q[CW-1:1]};
              col_addr_q <= {{(17 - CW){1'b0}}, col_q[CW-1:1]};
            end
            if (col_q == LAST) begin
              col_q <= '0;
              row_q <= row_q + 1'b1;
              if (row_q == LAST) state_q <= DONE;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready       = (state_q == RUN);
  assign busy           = (state_q != IDLE);
  assign layer2_done    = (state_q == DONE);
  assign save_enable    = save_en_q;
  assign save_row_addr  = row_addr_q;
  assign save_col_addr  = col_addr_q;
  assign store_data_out = result_q;

endmodule

// File: tb/tb_layer2_maxpool_store.sv
// tb/tb_layer2_maxpool_store.sv - self-checking bench for layer2_maxpool_store
// Window-max reference model over whole frames, plus table-driven corner windows.
module tb_layer2_maxpool_store;
  localparam int W  = 28;
  localparam int OW = 14;
  localparam int VW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [VW-1:0] in_data = '0;
  logic          in_ready, save_enable, busy, layer2_done;
  logic [15:0]   save_row_addr, save_col_addr;
  logic [VW-1:0] store_data_out;

  always #5 clk = ~clk;

  layer2_maxpool_store #(.IN_WIDTH(W), .CH(8), .DW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .save_enable(save_enable), .save_row_addr(save_row_addr),
    .save_col_addr(save_col_addr), .store_data_out(store_data_out), .busy(busy),
    .layer2_done(layer2_done)
  );

  typedef struct {
    logic signed [15:0] p00, p01, p10, p11, expv;
  } win_t;
  win_t tbl [5];

  int n_chk = 0;
  int n_fail = 0;
  logic [VW-1:0] cur [W][W];
  logic [VW-1:0] exp_map [OW][OW];

  logic [15:0]   wr_row [$];
  logic [15:0]   wr_col [$];
  logic [VW-1:0] wr_data [$];
  int rd_ptr = 0;
  int done_cnt = 0, done_bad = 0, ready_bad = 0;
  int done_base = 0, bad_base = 0;

  // Monitor samples on the falling edge, half a cycle away from DUT updates.
  always @(negedge clk) begin
    if (save_enable) begin
      wr_row.push_back(save_row_addr);
      wr_col.push_back(save_col_addr);
      wr_data.push_back(store_data_out);
    end
    if (layer2_done) begin
      done_cnt <= done_cnt + 1;
      if (!(save_enable && save_row_addr == 16'(OW - 1) && save_col_addr == 16'(OW - 1)))
        done_bad <= done_bad + 1;
    end
    if (busy && !layer2_done && !in_ready) ready_bad <= ready_bad + 1;
  end

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < W; r++)
      for (int c = 0; c < W; c++) cur[r][c] = {8{16'((r * W + c) % 32768)}};
    for (int r = 0; r < OW; r++)
      for (int c = 0; c < OW; c++) exp_map[r][c] = {8{16'((2 * r + 1) * W + 2 * c + 1)}};
  endtask

  // mode 0: any value, 1: non-negative only, 2: negative only
  task automatic fill_rand(input int mode);
    logic [15:0] v;
    for (int r = 0; r < W; r++)
      for (int c = 0; c < W; c++)
        for (int k = 0; k < 8; k++) begin
          v = 16'($urandom);
          if (mode == 1) v[15] = 1'b0;
          if (mode == 2) v[15] = 1'b1;
          cur[r][c][k*16 +: 16] = v;
        end
  endtask

  task automatic build_exp();
    logic signed [15:0] m, v;
    for (int r = 0; r < OW; r++)
      for (int c = 0; c < OW; c++)
        for (int k = 0; k < 8; k++) begin
          m = cur[2*r][2*c][k*16 +: 16];
          for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++) begin
              v = cur[2*r+dr][2*c+dc][k*16 +: 16];
              if (v > m) m = v;
            end
          exp_map[r][c][k*16 +: 16] = m;
        end
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic stream(input int npix, input bit toggle, input int start_at);
    for (int i = 0; i < npix; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = cur[i / W][i % W];
      start    = (i == start_at);
      if (toggle) begin
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        in_data  = {4{$urandom}};
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (!layer2_done && done_cnt <= done_base && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({nm, " done timeout"}, VW'(k < 200), VW'(1));
  endtask

  task automatic check_pass(input string nm);
    int avail;
    avail = wr_row.size() - rd_ptr;
    chk({nm, " write count"}, VW'(avail), VW'(OW * OW));
    for (int i = 0; i < OW * OW && i < avail; i++) begin
      chk($sformatf("%s addr%0d", nm, i), VW'({wr_row[rd_ptr+i], wr_col[rd_ptr+i]}),
          VW'({16'(i / OW), 16'(i % OW)}));
      chk($sformatf("%s data%0d", nm, i), wr_data[rd_ptr+i], exp_map[i / OW][i % OW]);
    end
    rd_ptr += avail;
    chk({nm, " done pulses"}, VW'(done_cnt - done_base), VW'(1));
    chk({nm, " done with last write"}, VW'(done_bad - bad_base), VW'(0));
    done_base = done_cnt;
    bad_base  = done_bad;
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, " in_ready"}, VW'(in_ready), VW'(0));
    chk({nm, " busy"}, VW'(busy), VW'(0));
    chk({nm, " save_enable"}, VW'(save_enable), VW'(0));
    chk({nm, " row_addr"}, VW'(save_row_addr), VW'(0));
    chk({nm, " col_addr"}, VW'(save_col_addr), VW'(0));
    chk({nm, " data"}, store_data_out, VW'(0));
    chk({nm, " layer2_done"}, VW'(layer2_done), VW'(0));
  endtask

  task automatic full_pass(input string nm, input bit toggle, input int start_at);
    do_start();
    stream(W * W, toggle, start_at);
    wait_done(nm);
    repeat (3) @(negedge clk);
    check_pass(nm);
  endtask

  initial begin
    int rb;
    logic [VW-1:0] pk;
    tbl[0] = '{-16'sd5, -16'sd3, -16'sd7, -16'sd2, -16'sd2};
    tbl[1] = '{16'sh7FFF, -16'sd1, -16'sd2, -16'sd3, 16'sh7FFF};
    tbl[2] = '{16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000};
    tbl[3] = '{-16'sd1, 16'sd0, 16'sh8000, 16'sd1, 16'sd1};
    tbl[4] = '{16'sd100, -16'sd200, 16'sd300, -16'sd400, 16'sd300};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");

    fill_ramp();
    full_pass("ramp", 1'b0, -1);

    for (int t = 0; t < 5; t++) begin
      fill_rand(0);
      cur[0][0][15:0] = tbl[t].p00;
      cur[0][1][15:0] = tbl[t].p01;
      cur[1][0][15:0] = tbl[t].p10;
      cur[1][1][15:0] = tbl[t].p11;
      build_exp();
      do_start();
      stream(W * W, 1'b0, -1);
      wait_done($sformatf("win%0d", t));
      repeat (3) @(negedge clk);
      pk = (wr_data.size() > rd_ptr) ? wr_data[rd_ptr] : 'x;
      chk($sformatf("win%0d ch0", t), {112'd0, pk[15:0]}, {112'd0, tbl[t].expv});
      check_pass($sformatf("win%0d", t));
    end

    fill_ramp();
    rb = ready_bad;
    full_pass("toggle", 1'b1, -1);
    chk("toggle in_ready in RUN", VW'(ready_bad - rb), VW'(0));

    fill_rand(0);
    build_exp();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = {4{$urandom}};
      chk($sformatf("idle busy%0d", i), VW'({busy, in_ready}), VW'(0));
    end
    @(negedge clk); in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle spurious writes", VW'(wr_row.size() - rd_ptr), VW'(0));
    full_pass("start_in_run", 1'b0, 300);

    fill_ramp();
    do_start();
    stream(400, 1'b0, -1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("midrst");
    repeat (40) @(negedge clk);
    chk("midrst writes", VW'(wr_row.size() - rd_ptr), VW'(98));
    chk("midrst no done", VW'(done_cnt - done_base), VW'(0));
    rd_ptr    = wr_row.size();
    done_base = done_cnt;
    bad_base  = done_bad;
    full_pass("after_rst", 1'b0, -1);

    fill_rand(1);
    build_exp();
    do_start();
    stream(W * W, 1'b0, -1);
    wait_done("b2b_a");
    do_start();
    check_pass("b2b_a");
    fill_rand(2);
    build_exp();
    stream(W * W, 1'b0, -1);
    wait_done("b2b_b");
    repeat (3) @(negedge clk);
    check_pass("b2b_b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
